// File: rtl/spi_cfg_ctrl.sv
// spi_cfg_ctrl: SPI-slave config register file; readback guarded by SPI_CFG_READBACK_EN
module spi_cfg_ctrl #(
  parameter int NREG = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [8*NREG-1:0] cfg_regs,
  output logic              cfg_wr,
  output logic [6:0]        cfg_addr
);
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] sck_s, cs_s, mosi_s;
  logic sck_d, cs_d, rise, mosi_q, rw, last, commit;
  logic [2:0] cnt;
  logic [7:0] sr;
  logic [6:0] addr;
  logic [7:0] byte_in;
  assign byte_in = {sr[6:0], mosi_q};
  assign last = rise && cnt == 3'd7;
  assign commit = state == DATA && last && !rw && 32'(addr) < NREG;
  // pin synchronizers plus registered sck-rise pulse aligned with mosi and cs level
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sck_s  <= '0;
      cs_s   <= 2'b11;
      mosi_s <= '0;
      sck_d  <= 1'b0;
      cs_d   <= 1'b1;
      rise   <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      sck_s  <= {sck_s[0], spi_sck};
      cs_s   <= {cs_s[0], spi_cs_n};
      mosi_s <= {mosi_s[0], spi_mosi};
      sck_d  <= sck_s[1];
      cs_d   <= cs_s[1];
      rise   <= sck_s[1] & ~sck_d;
      mosi_q <= mosi_s[1];
    end
  // next state: an sck edge coinciding with cs release is consumed before returning to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = cs_d ? IDLE : CMD;
      CMD:     state_nx = cs_d ? IDLE : (last ? DATA : CMD);
      DATA:    state_nx = last ? (cs_d ? IDLE : DONE) : (cs_d ? IDLE : DATA);
      default: state_nx = cs_d ? IDLE : DONE;
    endcase
  end
  // state, shifter, command latch and register file
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= '0;
      rw       <= 1'b0;
      addr     <= '0;
      cfg_regs <= '0;
      cfg_wr   <= 1'b0;
      cfg_addr <= '0;
    end else begin
      state  <= state_nx;
      cfg_wr <= commit;
      if (state == IDLE || cs_d) cnt <= '0;
      else if (rise && (state == CMD || state == DATA)) cnt <= cnt + 3'd1;
      if (rise && (state == CMD || state == DATA)) sr <= byte_in;
      if (state == CMD && last) begin
        rw   <= sr[6];
        addr <= byte_in[6:0];
      end
      if (commit) cfg_addr <= addr;
      for (int i = 0; i < NREG; i++)
        if (commit && addr == 7'(i)) cfg_regs[8*i +: 8] <= byte_in;
    end
`ifdef SPI_CFG_READBACK_EN
  logic fall;
  logic [7:0] rd_val, rd_sr;
  // selected register for readback; out-of-range addresses read as zero
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NREG; i++)
      if (byte_in[6:0] == 7'(i)) rd_val = cfg_regs[8*i +: 8];
  end
  // MISO shifts out MSB first on each detected sck fall during a read's data byte
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      fall     <= 1'b0;
      rd_sr    <= '0;
      spi_miso <= 1'b0;
    end else begin
      fall <= ~sck_s[1] & sck_d;
      if (state == CMD && last) rd_sr <= rd_val;
      else if (state == DATA && fall) rd_sr <= {rd_sr[6:0], 1'b0};
      spi_miso <= (state == DATA && rw) ? (fall ? rd_sr[7] : spi_miso) : 1'b0;
    end
`else
  assign spi_miso = 1'b0;
`endif
endmodule
